cirno_sequencer: RTL and testbench
==================================

Name: cirno_sequencer

Overview:
- Multi-cycle control FSM for the 9-bit Cirno core.
- Owns the PC and sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives decoder_en into the instruction decoder and consumes its registered outputs (inst_type, branch, branchi, immediate, done).
- Issues one-hot enables to the register file, ALU and data memory, and counts retired instructions.

Parameters:
- PC_W, 8, PC width in bits; all PC arithmetic is modulo 2^PC_W.
- IMM_W, 6, width of the decoder immediate field.
- MEM_TIMEOUT, 15, maximum cycles to wait for imem_ready/dmem_ready before faulting.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin execution at PC 0 (sampled in IDLE/HALT)
- imem_ready  in  1  instruction word valid on decoder input
- dmem_ready  in  1  data memory access complete
- inst_type  in  3  decoder class: 1 ALU, 2 imm-branch/nop, 3 reg-branch, 4 mov/sh, 5 store, 6 load
- branch  in  1  decoder: take register-target branch
- branchi  in  1  decoder: take PC-relative immediate branch
- done  in  1  decoder: halt instruction seen
- immediate  in  IMM_W  decoder immediate (signed for branchi)
- reg_target  in  PC_W  register value for register branches
- pc  out  PC_W  current instruction address
- fetch_en  out  1  instruction memory read request
- decoder_en  out  1  one-cycle decode strobe
- alu_en  out  1  ALU operate strobe
- dmem_rd_en  out  1  load request, held until dmem_ready
- dmem_wr_en  out  1  store request, held until dmem_ready
- reg_wr_en  out  1  register writeback strobe
- busy  out  1  FSM not in IDLE/HALT
- halted  out  1  HALT state
- fault  out  1  sticky: timeout or illegal inst_type
- inst_count  out  16  retired instruction count, wraps at 2^16

Behaviour:
- Reset (async, rst_n=0): state IDLE; pc=0, inst_count=0, fault=0; all enables 0; busy=0, halted=0.
- Outputs are registered as Moore outputs of the current state.
- IDLE: start=1 -> FETCH, pc<=0, inst_count<=0, fault<=0.
- FETCH: fetch_en=1 held.
  - imem_ready=1 -> DECODE.
  - MEM_TIMEOUT consecutive cycles without ready -> fault<=1, HALT.
- DECODE: decoder_en=1 for exactly one cycle -> EXEC. Decoder outputs are valid from EXEC onward.
- EXEC, evaluated in priority order:
  - done=1 -> HALT; retires, inst_count+1; pc unchanged.
  - inst_type=1 -> alu_en=1 -> WB.
  - inst_type=4 -> WB.
  - inst_type=2 -> pc <= pc + sext(immediate) if branchi, else pc+1; retire; -> FETCH.
  - inst_type=3 -> pc <= reg_target if branch, else pc+1; retire; -> FETCH.
  - inst_type=5/6 -> MEM.
  - inst_type=0 or 7 -> fault<=1, pc+1, no retire, -> FETCH.
- MEM: dmem_wr_en (type 5) or dmem_rd_en (type 6) held until dmem_ready.
  - Load completes -> WB.
  - Store completes -> pc+1, retire, -> FETCH.
  - MEM_TIMEOUT cycles without ready -> fault<=1, HALT; enables drop next cycle.
- WB: reg_wr_en=1 for one cycle; pc+1; retire; -> FETCH.
- HALT: halted=1, busy=0. start=1 restarts exactly as from IDLE.
- Latency (ready held high): ALU/mov 4 cycles; branch 3; store 4 (+waits); load 5 (+waits); a single-cycle ready pulse is accepted.
- Boundaries:
  - pc=2^PC_W-1 +1 wraps to 0.
  - Negative branch offsets wrap modulo 2^PC_W.
  - Timeout counter resets on every state entry.
  - start is ignored while busy.
  - rst_n low mid-access drops all enables immediately.

Optional Feature:
- Macro: CIRNO_SEQ_STEP_EN.
- Defined:
  - Adds input step (1 bit) and state PAUSE.
  - Every retire that would go to FETCH goes to PAUSE instead; busy stays 1, all enables 0.
  - A rising edge of step -> FETCH.
  - Retire into HALT is unchanged.
- Undefined: port step and state PAUSE are absent; behaviour is as above.

Test Plan:
- Reset, start pulse, ready tied 1, stream type1 (ALU) x3 then done -> alu_en each 4 cycles; pc 0,1,2,3; halted=1; inst_count=4.
- Type2 with branchi=1, immediate=6'b111110 at pc=5 -> pc=3; branchi=0 -> pc=6; type3 branch=1, reg_target=8'h40 -> pc=0x40.
- Type6 load, dmem_ready delayed 3 cycles -> dmem_rd_en high 4 cycles, then reg_wr_en one cycle, pc+1.
- Type5 store, dmem_ready never asserted -> after 15 cycles fault=1, halted=1, dmem_wr_en=0.
- pc=8'hFF ALU retire -> pc=0; inst_type=7 -> fault=1, inst_count unchanged; rst_n low mid-FETCH -> fetch_en 0 same cycle, pc=0.
- CIRNO_SEQ_STEP_EN: after first retire, FSM in PAUSE, no fetch for 10 cycles; step pulse -> fetch_en next cycle.

Source files
------------

// File: rtl/cirno_sequencer.sv
// Purpose: multi-cycle control FSM for the 9-bit Cirno core; owns the PC and retire counter.
// Latency: ALU/mov 4 cycles, branch 3, store 4 (+waits), load 5 (+waits) with ready held high.
// Backpressure: holds fetch_en / dmem_*_en until ready; faults and halts after MEM_TIMEOUT cycles.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin execution at PC 0 (sampled only in IDLE/HALT)
//   imem_ready/dmem_ready instruction word valid / data access complete
//   inst_type, branch, branchi, done, immediate   registered decoder outputs
//   reg_target            register value used by register-target branches
//   pc                    current instruction address
//   fetch_en, decoder_en, alu_en, dmem_rd_en, dmem_wr_en, reg_wr_en   unit enables
//   busy, halted, fault   status (fault is sticky until the next start)
//   inst_count            retired instruction count, wraps at 2^16
// Build option: define CIRNO_SEQ_STEP_EN to add the step input and a PAUSE state
// entered after every retire that would otherwise return to FETCH.

module cirno_sequencer #(
  parameter int PC_W        = 8,
  parameter int IMM_W       = 6,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef CIRNO_SEQ_STEP_EN
  input  logic             step,
`endif
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic [2:0]       inst_type,
  input  logic             branch,
  input  logic             branchi,
  input  logic             done,
  input  logic [IMM_W-1:0] immediate,
  input  logic [PC_W-1:0]  reg_target,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_en,
  output logic             decoder_en,
  output logic             alu_en,
  output logic             dmem_rd_en,
  output logic             dmem_wr_en,
  output logic             reg_wr_en,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [15:0]      inst_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
`ifdef CIRNO_SEQ_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  // Where a retiring instruction goes when it does not halt the core.
`ifdef CIRNO_SEQ_STEP_EN
  localparam state_t RET_ST    = S_PAUSE;
  localparam logic   RET_FETCH = 1'b0;
`else
  localparam state_t RET_ST    = S_FETCH;
  localparam logic   RET_FETCH = 1'b1;
`endif

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              mem_load;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   pc_rel;
  logic [PC_W-1:0]   imm_sext;
  logic              tmo_hit;

  assign pc_inc   = pc + PC_W'(1);
  assign imm_sext = {{(PC_W-IMM_W){immediate[IMM_W-1]}}, immediate};
  assign pc_rel   = pc + imm_sext;
  // Counter starts at 0 on entry, so the last waiting cycle is MEM_TIMEOUT-1.
  assign tmo_hit  = (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));

`ifdef CIRNO_SEQ_STEP_EN
  logic step_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end
`endif

  // All outputs are registered alongside the state they belong to: each
  // transition sets the enables of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= '0;
      inst_count <= '0;
      fault      <= 1'b0;
      tmo_cnt    <= '0;
      mem_load   <= 1'b0;
      fetch_en   <= 1'b0;
      decoder_en <= 1'b0;
      alu_en     <= 1'b0;
      dmem_rd_en <= 1'b0;
      dmem_wr_en <= 1'b0;
      reg_wr_en  <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
    end else begin
      // Single-cycle strobes and the wait counter clear unless re-armed below;
      // only the waiting branches of FETCH and MEM advance the counter.
      decoder_en <= 1'b0;
      alu_en     <= 1'b0;
      reg_wr_en  <= 1'b0;
      tmo_cnt    <= '0;

      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state      <= S_FETCH;
            pc         <= '0;
            inst_count <= '0;
            fault      <= 1'b0;
            fetch_en   <= 1'b1;
            busy       <= 1'b1;
            halted     <= 1'b0;
          end
        end

        S_FETCH: begin
          if (imem_ready) begin
            state      <= S_DECODE;
            fetch_en   <= 1'b0;
            decoder_en <= 1'b1;
          end else if (tmo_hit) begin
            state    <= S_HALT;
            fault    <= 1'b1;
            fetch_en <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        S_DECODE: state <= S_EXEC;

        S_EXEC: begin
          if (done) begin
            state      <= S_HALT;
            inst_count <= inst_count + 16'd1;
            busy       <= 1'b0;
            halted     <= 1'b1;
          end else begin
            case (inst_type)
              3'd1: begin
                // ALU result is written back in the same WB cycle it is computed.
                state     <= S_WB;
                alu_en    <= 1'b1;
                reg_wr_en <= 1'b1;
              end
              3'd4: begin
                state     <= S_WB;
                reg_wr_en <= 1'b1;
              end
              3'd2: begin
                pc         <= branchi ? pc_rel : pc_inc;
                inst_count <= inst_count + 16'd1;
                state      <= RET_ST;
                fetch_en   <= RET_FETCH;
              end
              3'd3: begin
                pc         <= branch ? reg_target : pc_inc;
                inst_count <= inst_count + 16'd1;
                state      <= RET_ST;
                fetch_en   <= RET_FETCH;
              end
              3'd5: begin
                state      <= S_MEM;
                mem_load   <= 1'b0;
                dmem_wr_en <= 1'b1;
              end
              3'd6: begin
                state      <= S_MEM;
                mem_load   <= 1'b1;
                dmem_rd_en <= 1'b1;
              end
              default: begin
                // Illegal class: skip it without retiring.
                fault    <= 1'b1;
                pc       <= pc_inc;
                state    <= S_FETCH;
                fetch_en <= 1'b1;
              end
            endcase
          end
        end

        S_MEM: begin
          if (dmem_ready) begin
            dmem_rd_en <= 1'b0;
            dmem_wr_en <= 1'b0;
            if (mem_load) begin
              state     <= S_WB;
              reg_wr_en <= 1'b1;
            end else begin
              pc         <= pc_inc;
              inst_count <= inst_count + 16'd1;
              state      <= RET_ST;
              fetch_en   <= RET_FETCH;
            end
          end else if (tmo_hit) begin
            state      <= S_HALT;
            fault      <= 1'b1;
            dmem_rd_en <= 1'b0;
            dmem_wr_en <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        S_WB: begin
          pc         <= pc_inc;
          inst_count <= inst_count + 16'd1;
          state      <= RET_ST;
          fetch_en   <= RET_FETCH;
        end

`ifdef CIRNO_SEQ_STEP_EN
        S_PAUSE: begin
          if (step && !step_q) begin
            state    <= S_FETCH;
            fetch_en <= 1'b1;
          end
        end
`endif

        default: begin
          state    <= S_IDLE;
          fetch_en <= 1'b0;
          busy     <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cirno_sequencer.sv
// Purpose: directed self-checking bench for cirno_sequencer with hand-computed expectations.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Backpressure: ready lines are driven directly to exercise waits, pulses and timeouts.

module tb_cirno_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
`ifdef CIRNO_SEQ_STEP_EN
  logic        step;
`endif
  logic        imem_ready;
  logic        dmem_ready;
  logic [2:0]  inst_type;
  logic        branch;
  logic        branchi;
  logic        done;
  logic [5:0]  immediate;
  logic [7:0]  reg_target;
  logic [7:0]  pc;
  logic        fetch_en;
  logic        decoder_en;
  logic        alu_en;
  logic        dmem_rd_en;
  logic        dmem_wr_en;
  logic        reg_wr_en;
  logic        busy;
  logic        halted;
  logic        fault;
  logic [15:0] inst_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cirno_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
`ifdef CIRNO_SEQ_STEP_EN
    .step       (step),
`endif
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .inst_type  (inst_type),
    .branch     (branch),
    .branchi    (branchi),
    .done       (done),
    .immediate  (immediate),
    .reg_target (reg_target),
    .pc         (pc),
    .fetch_en   (fetch_en),
    .decoder_en (decoder_en),
    .alu_en     (alu_en),
    .dmem_rd_en (dmem_rd_en),
    .dmem_wr_en (dmem_wr_en),
    .reg_wr_en  (reg_wr_en),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault),
    .inst_count (inst_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After a retire, the step build parks in PAUSE; nudge it back to FETCH.
  task automatic resume();
`ifdef CIRNO_SEQ_STEP_EN
    step = 1'b1;
    tick();
    step = 1'b0;
`endif
  endtask

  // FETCH -> DECODE -> EXEC -> (retire) FETCH for a branch-class instruction.
  task automatic do_branch(input string tag, input logic [7:0] exp_pc);
    tick();
    tick();
    tick();
    resume();
    chk(tag, 32'(pc), 32'(exp_pc));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    inst_type = 3'd0; branch = 1'b0; branchi = 1'b0; done = 1'b0;
    immediate = '0; reg_target = '0;
`ifdef CIRNO_SEQ_STEP_EN
    step = 1'b0;
`endif
    #1;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_fetch_en", 32'(fetch_en), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_count", 32'(inst_count), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // Three ALU instructions then a halt.
    inst_type = 3'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_fetch_en", 32'(fetch_en), 1);
    chk("start_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("alu_decoder_en", 32'(decoder_en), 1);
      tick();
      chk("alu_decoder_once", 32'(decoder_en), 0);
      tick();
      chk("alu_en", 32'(alu_en), 1);
      chk("alu_reg_wr_en", 32'(reg_wr_en), 1);
      chk("alu_wb_pc", 32'(pc), 32'(i));
      tick();
      resume();
      chk("alu_next_fetch", 32'(fetch_en), 1);
      chk("alu_next_pc", 32'(pc), 32'(i + 1));
    end
    done = 1'b1;
    tick();
    tick();
    tick();
    done = 1'b0;
    chk("halt_halted", 32'(halted), 1);
    chk("halt_busy", 32'(busy), 0);
    chk("halt_pc", 32'(pc), 3);
    chk("halt_count", 32'(inst_count), 4);

    // Branches; start held during one of them must be ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_pc", 32'(pc), 0);
    chk("restart_count", 32'(inst_count), 0);
    inst_type = 3'd3; branch = 1'b1; reg_target = 8'h05;
    do_branch("br_to_5", 8'h05);
    inst_type = 3'd2; branchi = 1'b1; immediate = 6'b111110; start = 1'b1;
    do_branch("bi_minus2", 8'h03);
    start = 1'b0;
    inst_type = 3'd3; reg_target = 8'h05;
    do_branch("br_to_5b", 8'h05);
    inst_type = 3'd2; branchi = 1'b0;
    do_branch("bi_not_taken", 8'h06);
    inst_type = 3'd3; branch = 1'b1; reg_target = 8'h40;
    do_branch("br_to_40", 8'h40);
    branch = 1'b0;
    do_branch("br_not_taken", 8'h41);
    chk("branch_count", 32'(inst_count), 6);

    // Load with dmem_ready arriving in the fourth MEM cycle as a one-cycle pulse.
    inst_type = 3'd6; dmem_ready = 1'b0;
    tick();
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("ld_rd_en_held", 32'(dmem_rd_en), 1);
      if (k == 3) dmem_ready = 1'b1;
      tick();
    end
    dmem_ready = 1'b0;
    chk("ld_rd_en_drop", 32'(dmem_rd_en), 0);
    chk("ld_reg_wr_en", 32'(reg_wr_en), 1);
    chk("ld_alu_en", 32'(alu_en), 0);
    tick();
    resume();
    chk("ld_reg_wr_once", 32'(reg_wr_en), 0);
    chk("ld_pc", 32'(pc), 8'h42);
    chk("ld_count", 32'(inst_count), 7);

    // Store that never completes: 15 MEM cycles then fault/halt.
    inst_type = 3'd5;
    tick();
    tick();
    tick();
    for (int k = 0; k < 14; k++) tick();
    chk("st_wr_en_last", 32'(dmem_wr_en), 1);
    chk("st_no_fault_yet", 32'(fault), 0);
    tick();
    chk("st_tmo_fault", 32'(fault), 1);
    chk("st_tmo_halted", 32'(halted), 1);
    chk("st_tmo_wr_en", 32'(dmem_wr_en), 0);
    chk("st_tmo_count", 32'(inst_count), 7);

    // Fetch that never completes.
    imem_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ft_restart_fault", 32'(fault), 0);
    for (int k = 0; k < 14; k++) tick();
    chk("ft_fetch_en_last", 32'(fetch_en), 1);
    chk("ft_halted_yet", 32'(halted), 0);
    tick();
    chk("ft_tmo_fault", 32'(fault), 1);
    chk("ft_tmo_fetch_en", 32'(fetch_en), 0);
    chk("ft_tmo_halted", 32'(halted), 1);

    // Negative wrap to 0xFF, increment wrap to 0, illegal class, reset mid-fetch.
    imem_ready = 1'b1; dmem_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    inst_type = 3'd2; branchi = 1'b1; immediate = 6'b111111;
    do_branch("bi_wrap_ff", 8'hFF);
    inst_type = 3'd1;
    tick();
    tick();
    tick();
    tick();
    resume();
    chk("alu_wrap_pc", 32'(pc), 0);
    chk("wrap_count", 32'(inst_count), 2);
    inst_type = 3'd7;
    tick();
    tick();
    tick();
    chk("ill_fault", 32'(fault), 1);
    chk("ill_pc", 32'(pc), 1);
    chk("ill_count", 32'(inst_count), 2);
    chk("ill_fetch_en", 32'(fetch_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_fetch_en", 32'(fetch_en), 0);
    chk("arst_pc", 32'(pc), 0);
    chk("arst_fault", 32'(fault), 0);
    chk("arst_busy", 32'(busy), 0);

`ifdef CIRNO_SEQ_STEP_EN
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    inst_type = 3'd3; branch = 1'b0;
    tick();
    tick();
    tick();
    chk("pause_fetch_en", 32'(fetch_en), 0);
    chk("pause_busy", 32'(busy), 1);
    begin
      int fetches = 0;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (fetch_en) fetches++;
      end
      chk("pause_no_fetch", 32'(fetches), 0);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_fetch_en", 32'(fetch_en), 1);
    chk("step_pc", 32'(pc), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
